// File: rtl/legv8_program_counter.sv
// Purpose : LEGv8 fetch-stage program counter with prioritised redirects, flush window and EPC capture.
// Latency : redirect sampled at edge N is visible on pc after edge N; flush pulses for the following cycle.
// Backpres: stall holds pc in RUN only; fetch_valid drops for FLUSH_CYCLES cycles after every redirect.
module legv8_program_counter #(
    parameter int                    ADDR_WIDTH   = 8,
    parameter int                    OFFSET_WIDTH = 8,
    parameter int                    STEP         = 1,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
    parameter logic [ADDR_WIDTH-1:0] EXC_VECTOR   = ADDR_WIDTH'(8'h80),
    parameter int                    FLUSH_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    stall,
    input  logic                    branch_taken,
    input  logic [OFFSET_WIDTH-1:0] branch_offset,
    input  logic                    jump_reg,
    input  logic [ADDR_WIDTH-1:0]   jump_target,
    input  logic                    exception,
    output logic [ADDR_WIDTH-1:0]   pc,
    output logic [ADDR_WIDTH-1:0]   pc_plus_step,
    output logic                    fetch_valid,
    output logic                    flush,
    output logic [ADDR_WIDTH-1:0]   epc
);

    // BOOT: one dead cycle after reset. RUN: normal fetch. FLUSH: squash window after a redirect.
    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    // Window counter starts at FLUSH_CYCLES-1 so the window lasts exactly FLUSH_CYCLES cycles.
    localparam logic [3:0]            CNT_RELOAD = 4'(FLUSH_CYCLES - 1);
    localparam logic [ADDR_WIDTH-1:0] STEP_A     = ADDR_WIDTH'(STEP);

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
    logic [ADDR_WIDTH-1:0]   epc_q, epc_d;
    logic                    fetch_valid_q, fetch_valid_d;
    logic                    flush_q, flush_d;

    logic [ADDR_WIDTH-1:0]   seq_pc;
    logic [ADDR_WIDTH-1:0]   offset_ext;
    logic [ADDR_WIDTH-1:0]   branch_pc;

    // Sequential and PC-relative targets; all arithmetic wraps modulo 2^ADDR_WIDTH.
    assign seq_pc     = pc_q + STEP_A;
    assign offset_ext = ADDR_WIDTH'($signed(branch_offset));
    assign branch_pc  = pc_q + ADDR_WIDTH'(offset_ext * STEP_A);

    // Next-state selection: exception wins everywhere; other redirects only count in RUN.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pc_d    = pc_q;
        epc_d   = epc_q;
        flush_d = 1'b0;
        case (state_q)
            ST_BOOT: begin
                if (exception) begin
                    pc_d    = EXC_VECTOR;
                    epc_d   = pc_q;
                    cnt_d   = CNT_RELOAD;
                    flush_d = 1'b1;
                    state_d = ST_FLUSH;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (exception) begin
                    pc_d    = EXC_VECTOR;
                    epc_d   = pc_q;
                    cnt_d   = CNT_RELOAD;
                    flush_d = 1'b1;
                    state_d = ST_FLUSH;
                end else if (jump_reg) begin
                    pc_d    = jump_target;
                    cnt_d   = CNT_RELOAD;
                    flush_d = 1'b1;
                    state_d = ST_FLUSH;
                end else if (branch_taken) begin
                    pc_d    = branch_pc;
                    cnt_d   = CNT_RELOAD;
                    flush_d = 1'b1;
                    state_d = ST_FLUSH;
                end else if (!stall) begin
                    pc_d    = seq_pc;
                end
            end
            ST_FLUSH: begin
                // Jump/branch/stall here come from squashed instructions and are dropped.
                if (exception) begin
                    pc_d    = EXC_VECTOR;
                    epc_d   = pc_q;
                    cnt_d   = CNT_RELOAD;
                    flush_d = 1'b1;
                end else if (cnt_q == 4'd0) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d   = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_BOOT;
                cnt_d   = 4'd0;
            end
        endcase
        fetch_valid_d = (state_d == ST_RUN);
    end

    // State, pc, epc and the registered status outputs; reset clears everything at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_BOOT;
            cnt_q         <= 4'd0;
            pc_q          <= RESET_VECTOR;
            epc_q         <= '0;
            fetch_valid_q <= 1'b0;
            flush_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            pc_q          <= pc_d;
            epc_q         <= epc_d;
            fetch_valid_q <= fetch_valid_d;
            flush_q       <= flush_d;
        end
    end

    assign pc           = pc_q;
    assign pc_plus_step = seq_pc;
    assign fetch_valid  = fetch_valid_q;
    assign flush        = flush_q;
    assign epc          = epc_q;

endmodule

// File: tb/tb_legv8_program_counter.sv
module tb_legv8_program_counter;

    localparam int AW   = 8;
    localparam int MASK = (1 << AW) - 1;
    localparam int STEP = 1;
    localparam int RV   = 0;
    localparam int EXC  = 'h80;
    localparam int FC   = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          stall = 1'b0;
    logic          branch_taken = 1'b0;
    logic [7:0]    branch_offset = 8'h00;
    logic          jump_reg = 1'b0;
    logic [AW-1:0] jump_target = '0;
    logic          exception = 1'b0;
    logic [AW-1:0] pc, pc_plus_step, epc;
    logic          fetch_valid, flush;

    int n_pass  = 0;
    int n_total = 0;

    legv8_program_counter dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .jump_reg      (jump_reg),
        .jump_target   (jump_target),
        .exception     (exception),
        .pc            (pc),
        .pc_plus_step  (pc_plus_step),
        .fetch_valid   (fetch_valid),
        .flush         (flush),
        .epc           (epc)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else
            n_pass++;
    endtask

    // Behavioural model: m_dead = number of upcoming cycles (including the current one) with no valid fetch.
    int m_pc = RV;
    int m_epc = 0;
    int m_dead = 1;
    int m_flush = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pc = RV; m_epc = 0; m_dead = 1; m_flush = 0;
        end else begin
            m_flush = 0;
            if (exception) begin
                m_epc = m_pc; m_pc = EXC; m_dead = FC; m_flush = 1;
            end else if (m_dead == 0) begin
                if (jump_reg) begin
                    m_pc = int'(jump_target); m_dead = FC; m_flush = 1;
                end else if (branch_taken) begin
                    m_pc = (m_pc + int'($signed(branch_offset)) * STEP) & MASK;
                    m_dead = FC; m_flush = 1;
                end else if (!stall) begin
                    m_pc = (m_pc + STEP) & MASK;
                end
            end else begin
                m_dead = m_dead - 1;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model, away from the active edge.
    always @(negedge clk) begin
        check("pc",           32'(pc),           32'(m_pc));
        check("pc_plus_step", 32'(pc_plus_step), 32'((m_pc + STEP) & MASK));
        check("epc",          32'(epc),          32'(m_epc));
        check("fetch_valid",  32'(fetch_valid),  32'(m_dead == 0));
        check("flush",        32'(flush),        32'(m_flush));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic clear_req();
        stall = 1'b0; branch_taken = 1'b0; branch_offset = 8'h00;
        jump_reg = 1'b0; jump_target = '0; exception = 1'b0;
    endtask

    initial begin
        // Reset, boot cycle, then 300 idle cycles with wrap.
        repeat (3) @(posedge clk);
        check("rst_pc", 32'(pc), 32'h00);
        check("rst_fv", 32'(fetch_valid), 32'h0);
        #1 reset = 1'b0;
        check("boot_fv", 32'(fetch_valid), 32'h0);
        for (int k = 0; k < 300; k++) begin
            tick();
            if (k == 0) begin
                check("first_fetch_pc", 32'(pc), 32'h00);
                check("first_fetch_fv", 32'(fetch_valid), 32'h1);
            end
            if (k == 255) begin
                check("max_pc", 32'(pc), 32'hFF);
                check("max_pc_plus", 32'(pc_plus_step), 32'h00);
            end
            if (k == 256) check("wrap_pc", 32'(pc), 32'h00);
        end

        // Stall three cycles at pc=5.
        do_reset();
        tick();
        repeat (5) tick();
        check("pre_stall_pc", 32'(pc), 32'h05);
        stall = 1'b1;
        repeat (3) tick();
        stall = 1'b0;
        check("stall_pc", 32'(pc), 32'h05);
        check("stall_flush", 32'(flush), 32'h0);
        tick();
        check("post_stall_pc", 32'(pc), 32'h06);
        check("post_stall_fv", 32'(fetch_valid), 32'h1);

        // Backward branch at 0x10.
        repeat (10) tick();
        check("pre_br_pc", 32'(pc), 32'h10);
        branch_taken = 1'b1; branch_offset = 8'hFC;
        tick();
        clear_req();
        check("br_pc", 32'(pc), 32'h0C);
        check("br_flush", 32'(flush), 32'h1);
        check("br_fv0", 32'(fetch_valid), 32'h0);
        tick();
        check("br_flush_end", 32'(flush), 32'h0);
        check("br_fv1", 32'(fetch_valid), 32'h0);
        tick();
        check("br_fetch_fv", 32'(fetch_valid), 32'h1);
        check("br_fetch_pc", 32'(pc), 32'h0C);

        // Branch below zero wraps.
        do_reset();
        repeat (3) tick();
        check("pre_wrapbr_pc", 32'(pc), 32'h02);
        branch_taken = 1'b1; branch_offset = 8'hFC;
        tick();
        clear_req();
        check("wrapbr_pc", 32'(pc), 32'hFE);
        repeat (2) tick();
        check("wrapbr_fv", 32'(fetch_valid), 32'h1);
        repeat (2) tick();
        check("wrapbr_seq", 32'(pc), 32'h00);

        // Priority: all requests at once, exception wins.
        do_reset();
        repeat (33) tick();
        check("pre_prio_pc", 32'(pc), 32'h20);
        exception = 1'b1; jump_reg = 1'b1; jump_target = 8'h40;
        branch_taken = 1'b1; branch_offset = 8'h03; stall = 1'b1;
        tick();
        clear_req();
        check("prio_pc", 32'(pc), 32'h80);
        check("prio_epc", 32'(epc), 32'h20);
        check("prio_flush", 32'(flush), 32'h1);
        repeat (2) tick();
        check("prio_fetch_fv", 32'(fetch_valid), 32'h1);
        jump_reg = 1'b1; jump_target = 8'h40; branch_taken = 1'b1; branch_offset = 8'h03;
        tick();
        clear_req();
        check("jmp_over_br_pc", 32'(pc), 32'h40);
        repeat (2) tick();
        check("jmp_fetch_fv", 32'(fetch_valid), 32'h1);

        // Requests inside the flush window.
        branch_taken = 1'b1; branch_offset = 8'h04;
        tick();
        clear_req();
        check("win_pc", 32'(pc), 32'h44);
        jump_reg = 1'b1; jump_target = 8'h99; branch_taken = 1'b1; branch_offset = 8'h10;
        tick();
        clear_req();
        check("win_ignored_pc", 32'(pc), 32'h44);
        check("win_ignored_flush", 32'(flush), 32'h0);
        check("win_ignored_fv", 32'(fetch_valid), 32'h0);
        exception = 1'b1;
        tick();
        clear_req();
        check("win_exc_pc", 32'(pc), 32'h80);
        check("win_exc_epc", 32'(epc), 32'h44);
        check("win_exc_flush", 32'(flush), 32'h1);
        tick();
        check("win_restart_fv", 32'(fetch_valid), 32'h0);
        tick();
        check("win_restart_done", 32'(fetch_valid), 32'h1);
        check("win_restart_pc", 32'(pc), 32'h80);

        // Asynchronous reset in the middle of a flush window.
        branch_taken = 1'b1; branch_offset = 8'h02;
        tick();
        clear_req();
        check("pre_arst_pc", 32'(pc), 32'h82);
        #2 reset = 1'b1;
        #1;
        check("arst_pc", 32'(pc), 32'h00);
        check("arst_epc", 32'(epc), 32'h00);
        check("arst_fv", 32'(fetch_valid), 32'h0);
        check("arst_flush", 32'(flush), 32'h0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Exception during the boot cycle.
        exception = 1'b1;
        tick();
        clear_req();
        check("boot_exc_pc", 32'(pc), 32'h80);
        check("boot_exc_epc", 32'(epc), 32'h00);
        check("boot_exc_flush", 32'(flush), 32'h1);
        repeat (2) tick();
        check("boot_exc_fetch", 32'(fetch_valid), 32'h1);

        tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
